bcd_display_scanner: RTL and testbench

//  Reader side of the BCD digit counters: takes NUM_DIGITS packed BCD digits and drives a

---
 rtl/display_pkg.sv | 13 +
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/bcd_display_scanner.sv | 103 ++++++++++
 tb/tb_bcd_display_scanner.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and segment constants for the 7-segment display blocks.
package display_pkg;

    // One packed BCD digit
    typedef logic [3:0] bcd_t;

    // Segment pattern {g,f,e,d,c,b,a}, active-low
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_OFF  = 7'h7F;
    localparam seg7_t SEG_DASH = 7'h3F;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 show a dash.
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg_n
);

    // Decode table, segments ordered {g,f,e,d,c,b,a}
    always_comb begin
        o_seg_n = SEG_DASH;
        case (i_digit)
            4'd0:    o_seg_n = 7'h40;
            4'd1:    o_seg_n = 7'h79;
            4'd2:    o_seg_n = 7'h24;
            4'd3:    o_seg_n = 7'h30;
            4'd4:    o_seg_n = 7'h19;
            4'd5:    o_seg_n = 7'h12;
            4'd6:    o_seg_n = 7'h02;
            4'd7:    o_seg_n = 7'h78;
            4'd8:    o_seg_n = 7'h00;
            4'd9:    o_seg_n = 7'h10;
            default: o_seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-anode display driver. One digit per slot, inputs
// snapshotted once per frame so a frame never mixes old and new digits.
module bcd_display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int GUARD      = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic                      blank_lz,
    output logic [6:0]                seg_n,
    output logic [NUM_DIGITS-1:0]     an_n,
    output logic                      frame_start
);

    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PRESC_W-1:0]      r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_snap;
    logic                    r_snap_lz;
    seg7_t                   r_seg_n;
    logic [NUM_DIGITS-1:0]   r_an_n;
    logic                    r_frame_start;

    logic                    w_tick;
    logic                    w_last;
    logic                    w_guard;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_blank_vec;
    bcd_t                    w_digit;
    seg7_t                   w_dec_seg_n;

    assign w_tick  = (r_presc == PRESC_W'(SCAN_DIV - 1));
    assign w_last  = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_guard = (r_presc < PRESC_W'(GUARD));
    assign w_digit = r_snap[4*r_idx +: 4];
    assign w_blank = w_blank_vec[r_idx];

    bcd_to_seg7 u_dec (
        .i_digit (w_digit),
        .o_seg_n (w_dec_seg_n)
    );

    // Leading-zero mask: digit i blanked when it and every higher digit are zero
    always_comb begin : blank_mask
        logic v_upper_zero;
        v_upper_zero = 1'b1;
        w_blank_vec  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_upper_zero = v_upper_zero && (r_snap[4*i +: 4] == 4'd0);
            if (i > 0) begin
                w_blank_vec[i] = r_snap_lz && v_upper_zero;
            end
        end
    end

    // Slot prescaler, scan index and once-per-frame snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc   <= '0;
            r_idx     <= '0;
            r_snap    <= '0;
            r_snap_lz <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_idx <= w_last ? '0 : r_idx + 1'b1;
                if (w_last) begin
                    r_snap    <= digits_in;
                    r_snap_lz <= blank_lz;
                end
            end
        end
    end

    // Registered outputs; all anodes off during the guard window or a blanked digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_n       <= SEG_OFF;
            r_an_n        <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_tick && w_last;
            if (w_guard || w_blank) begin
                r_seg_n <= SEG_OFF;
                r_an_n  <= '1;
            end else begin
                r_seg_n <= w_dec_seg_n;
                r_an_n  <= ~(NUM_DIGITS'(1) << r_idx);
            end
        end
    end

    assign seg_n       = r_seg_n;
    assign an_n        = r_an_n;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_bcd_display_scanner.sv
module tb_bcd_display_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic        blank_lz;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0]     d;
        logic            lz;
        logic [3:0][6:0] seg;
        logic [3:0]      blank;
    } vec_t;

    vec_t vecs [8];
    vec_t exp_q[$];
    bit   mon_en = 1'b1;

    always #5 clk = ~clk;

    bcd_display_scanner #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .GUARD      (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits_in   (digits_in),
        .blank_lz    (blank_lz),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    function automatic vec_t mk(input logic [15:0] d, input logic lz,
                                input logic [6:0] s3, input logic [6:0] s2,
                                input logic [6:0] s1, input logic [6:0] s0,
                                input logic [3:0] blank);
        vec_t v;
        v.d      = d;
        v.lz     = lz;
        v.seg[3] = s3;
        v.seg[2] = s2;
        v.seg[1] = s1;
        v.seg[0] = s0;
        v.blank  = blank;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Waits for the next frame_start, sampled on the falling edge
    task automatic wait_fs();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        chk("frame_start timeout", 32'(ok), 32'd1);
    endtask

    // After reset release: first frame shows snap=0, frame_start first at cycle 16
    task automatic post_reset();
        int first;
        first = 0;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk);
            #1;
            if (n == 2) begin
                chk("post-reset an_n", 32'(an_n), 32'hE);
                chk("post-reset seg_n", 32'(seg_n), 32'h40);
            end
            if (frame_start) begin
                first = n;
                break;
            end
        end
        chk("first frame_start cycle", 32'(first), 32'd16);
    endtask

    // Monitor: pops one expected frame per frame_start and checks its 16 samples
    initial begin
        int   k;
        int   since_fs;
        bit   active;
        vec_t cur;
        logic [3:0] one;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int   slot;
        int   p;
        k        = 0;
        since_fs = -1;
        active   = 1'b0;
        cur      = '0;
        one      = 4'b0001;
        forever begin
            @(negedge clk);
            n_checks++;
            if ($countones(~an_n) > 1) begin
                n_fail++;
                $display("FAIL an_n one-hot: got %b at %0t", an_n, $time);
            end
            if (mon_en) begin
                if (active) begin
                    k++;
                    if (k <= 16) begin
                        slot = (k - 1) / 4;
                        p    = (k - 1) % 4;
                        if (p == 0 || cur.blank[slot]) begin
                            exp_an  = 4'hF;
                            exp_seg = 7'h7F;
                        end else begin
                            exp_an  = ~(one << slot);
                            exp_seg = cur.seg[slot];
                        end
                        chk($sformatf("an_n %04h k%0d", cur.d, k), 32'(an_n), 32'(exp_an));
                        chk($sformatf("seg_n %04h k%0d", cur.d, k), 32'(seg_n), 32'(exp_seg));
                    end
                end
                if (since_fs >= 0) since_fs++;
                if (frame_start) begin
                    if (since_fs >= 0) chk("frame period", 32'(since_fs), 32'd16);
                    since_fs = 0;
                    k        = 0;
                    if (exp_q.size() > 0) begin
                        cur    = exp_q.pop_front();
                        active = 1'b1;
                    end else begin
                        active = 1'b0;
                    end
                end
            end else begin
                active   = 1'b0;
                since_fs = -1;
            end
        end
    end

    // Driver
    initial begin
        vecs[0] = mk(16'h1234, 1'b0, 7'h79, 7'h24, 7'h30, 7'h19, 4'b0000);
        vecs[1] = mk(16'h0007, 1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h78, 4'b1110);
        vecs[2] = mk(16'h0007, 1'b0, 7'h40, 7'h40, 7'h40, 7'h78, 4'b0000);
        vecs[3] = mk(16'h00A0, 1'b1, 7'h7F, 7'h7F, 7'h3F, 7'h40, 4'b1100);
        vecs[4] = mk(16'h0F00, 1'b1, 7'h7F, 7'h3F, 7'h40, 7'h40, 4'b1000);
        vecs[5] = mk(16'h0000, 1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b1110);
        vecs[6] = mk(16'h1000, 1'b1, 7'h79, 7'h40, 7'h40, 7'h40, 4'b0000);
        vecs[7] = mk(16'h9856, 1'b1, 7'h10, 7'h00, 7'h12, 7'h02, 4'b0000);

        rst       = 1'b1;
        digits_in = vecs[0].d;
        blank_lz  = vecs[0].lz;
        repeat (2) @(posedge clk);
        #1;
        chk("reset seg_n", 32'(seg_n), 32'h7F);
        chk("reset an_n", 32'(an_n), 32'hF);
        chk("reset frame_start", 32'(frame_start), 32'd0);

        exp_q.push_back(vecs[0]);
        @(negedge clk);
        rst = 1'b0;
        post_reset();

        // Each frame: scramble inputs early (must not show), then set the next vector
        for (int i = 1; i < 8; i++) begin
            digits_in = 16'h8888;
            blank_lz  = ~blank_lz;
            repeat (8) @(negedge clk);
            digits_in = vecs[i].d;
            blank_lz  = vecs[i].lz;
            exp_q.push_back(vecs[i]);
            wait_fs();
        end
        wait_fs();
        @(posedge clk);
        #1;
        chk("expected frames left", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a slot
        @(posedge clk);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk("mid reset seg_n", 32'(seg_n), 32'h7F);
        chk("mid reset an_n", 32'(an_n), 32'hF);
        chk("mid reset frame_start", 32'(frame_start), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        post_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
